melody_sequencer: RTL and testbench

Parametrised successor to `music_box`. It plays a melody from a writable note RAM instead of a fixed tune. Each entry holds a note code and a duration in beats, and the block drives a square-wave `speaker` output through a tone divider. Start and stop are controlled by pulses, with `busy` and `done` status outputs. It sits between the board clock (12 MHz by default) and the speaker pin, and a host-side loader fills the RAM.

---
 rtl/melody_pkg.sv | 13 +
 rtl/tone_gen.sv | 26 ++
 rtl/melody_sequencer.sv | 101 ++++++++++
 tb/tb_melody_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// melody_pkg: note codes, note frequency table, half-period helper and FSM states for melody_sequencer
package melody_pkg;
  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_A4   = 4'd10;
  localparam logic [3:0] NOTE_C5   = 4'd13;
  localparam logic [3:0] NOTE_D5   = 4'd15;
  localparam int NOTE_FREQ_HZ [16] = '{0, 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494, 523, 554, 587};
  function automatic int half_period(input int clk_hz, input int freq);
    return (freq == 0) ? 0 : clk_hz / (2 * freq);
  endfunction
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;
endpackage

// File: rtl/tone_gen.sv
// tone_gen: half-period divider producing a square wave, cleared to 0 by i_clr
module tone_gen #(
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [HP_W-1:0] i_hp,
  output logic            o_sq
);
  logic [HP_W-1:0] r_cnt;
  logic            r_sq;
  logic            w_wrap;
  assign w_wrap = r_cnt == i_hp - HP_W'(1);
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + HP_W'(1);
      r_sq  <= w_wrap ? ~r_sq : r_sq;
    end
  end
  assign o_sq = r_sq;
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays notes from a writable RAM as a square wave; define MELODY_LOOP_EN to loop the song forever
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int BEAT_HZ = 4,
  parameter int DEPTH   = 32,
  parameter int DUR_W   = 3,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [3:0]       wr_note,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [IDX_W:0]   song_len,
  input  logic             start,
  input  logic             stop,
  output logic             speaker,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx
);
  localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
  localparam int CYC_W    = $clog2(BEAT_CYC + 1);
  localparam int HP_W     = $clog2(half_period(CLK_HZ, NOTE_FREQ_HZ[NOTE_C4])) + 1;
`ifdef MELODY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic [DUR_W+3:0] r_mem [DEPTH];
  state_t           r_state, w_next;
  logic [3:0]       r_note;
  logic [DUR_W-1:0] r_dur, r_beat;
  logic [CYC_W-1:0] r_cyc;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W:0]   r_len;
  logic             r_done;
  logic             w_beat_end, w_end, w_last, w_clr;
  logic [HP_W-1:0]  w_hp_tab [NOTE_D5+1];
  for (genvar g = 0; g <= NOTE_D5; g++) begin : g_hp
    assign w_hp_tab[g] = HP_W'(half_period(CLK_HZ, NOTE_FREQ_HZ[g]));
  end
  always_ff @(posedge clk) begin
    if (wr_en && 32'(wr_addr) < DEPTH)
      r_mem[wr_addr] <= {wr_note, wr_dur};
  end
  always_comb begin
    w_beat_end = r_cyc == CYC_W'(BEAT_CYC - 1);
    w_end      = r_state == S_PLAY && w_beat_end && r_beat == r_dur;
    w_last     = ({1'b0, r_idx} + (IDX_W+1)'(1)) >= r_len;
    w_next     = stop ? S_IDLE :
                 r_state == S_IDLE  ? ((start && song_len != '0) ? S_FETCH : S_IDLE) :
                 r_state == S_FETCH ? S_PLAY :
                 !w_end             ? S_PLAY :
                 (w_last && !LOOP)  ? S_IDLE : S_FETCH;
    w_clr      = r_state != S_PLAY || w_next != S_PLAY;
    busy       = r_state != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
      r_note  <= '0;
      r_dur   <= '0;
      r_beat  <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_end && w_last && !LOOP && !stop;
      if (r_state == S_IDLE && w_next == S_FETCH) begin
        r_idx <= '0;
        r_len <= (song_len > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : song_len;
      end
      if (w_end && w_next == S_FETCH)
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      if (r_state == S_FETCH) begin
        {r_note, r_dur} <= r_mem[r_idx];
        r_cyc           <= '0;
        r_beat          <= '0;
      end else if (r_state == S_PLAY) begin
        r_cyc  <= w_beat_end ? '0 : r_cyc + CYC_W'(1);
        r_beat <= r_beat + DUR_W'(w_beat_end);
      end
    end
  end
  tone_gen #(.HP_W(HP_W)) u_tone (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (r_note != NOTE_REST),
    .i_hp  (w_hp_tab[r_note]),
    .o_sq  (speaker)
  );
  assign done     = r_done;
  assign note_idx = r_idx;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: scoreboard bench for melody_sequencer (define MELODY_LOOP_EN to run the loop scenario)
module tb_melody_sequencer;
  localparam int CLK_HZ = 12_000, BEAT_HZ = 100, BC = CLK_HZ / BEAT_HZ;
  localparam int DEPTH = 32, DUR_W = 3, IDX_W = 5, BIG = 1_000_000;
  localparam int FREQ [16] = '{0, 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494, 523, 554, 587};
  typedef struct {int c; int v;} ev_t;
  logic             clk = 0, rst = 1, wr_en = 0, start = 0, stop = 0;
  logic [IDX_W-1:0] wr_addr = '0;
  logic [3:0]       wr_note = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic [IDX_W:0]   song_len = '0;
  logic             speaker, busy, done;
  logic [IDX_W-1:0] note_idx;
  int   q_tog[$], q_done[$];
  ev_t  q_idx[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, t0 = 0, m_idx = 0;
  int   m_note [DEPTH], m_dur [DEPTH];
  bit   mon_en = 0;
  logic p_spk = 0;
  logic [IDX_W-1:0] p_idx = '0;

  melody_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur),
    .song_len(song_len), .start(start), .stop(stop), .speaker(speaker), .busy(busy), .done(done),
    .note_idx(note_idx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    int   e;
    ev_t  x;
    if (mon_en) begin
      if (speaker !== p_spk) begin
        n_chk++;
        if (q_tog.size() == 0) begin
          n_fail++;
          $display("FAIL spk_edge: unexpected change to %0b at cycle %0d", speaker, cyc - t0);
        end else begin
          e = q_tog.pop_front();
          if (cyc - t0 != e) begin
            n_fail++;
            $display("FAIL spk_edge: changed at cycle %0d, expected cycle %0d", cyc - t0, e);
          end
        end
      end
      if (done === 1'b1) begin
        n_chk++;
        if (q_done.size() == 0) begin
          n_fail++;
          $display("FAIL done: unexpected pulse at cycle %0d", cyc - t0);
        end else begin
          e = q_done.pop_front();
          if (cyc - t0 != e) begin
            n_fail++;
            $display("FAIL done: pulse at cycle %0d, expected cycle %0d", cyc - t0, e);
          end
        end
      end
      if (note_idx !== p_idx) begin
        n_chk++;
        if (q_idx.size() == 0) begin
          n_fail++;
          $display("FAIL note_idx: unexpected change to %0d at cycle %0d", note_idx, cyc - t0);
        end else begin
          x = q_idx.pop_front();
          if (cyc - t0 != x.c || int'(note_idx) != x.v) begin
            n_fail++;
            $display("FAIL note_idx: got %0d at cycle %0d, expected %0d at cycle %0d", note_idx, cyc - t0, x.v, x.c);
          end
        end
      end
    end
    p_spk = speaker;
    p_idx = note_idx;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 0;
    stop  = 0;
  endtask

  task automatic wr(input int a, input int n, input int d);
    tick();
    wr_en   = 1;
    wr_addr = IDX_W'(a);
    wr_note = 4'(n);
    wr_dur  = DUR_W'(d);
    tick();
    wr_en = 0;
    m_note[a] = n;
    m_dur[a]  = d;
  endtask

  task automatic launch(input int len);
    tick();
    start    = 1;
    song_len = (IDX_W+1)'(len);
    t0       = cyc;
  endtask

  task automatic model(input int n, input int stop_at, input bit loop);
    int  t, p, lc, hp, i;
    bit  par;
    ev_t x;
    t = 1; i = 0; par = 0;
    while (t <= stop_at) begin
      if (i != m_idx) begin
        x.c = t; x.v = i;
        q_idx.push_back(x);
        m_idx = i;
      end
      p  = t + 1;
      lc = (m_dur[i] + 1) * BC;
      if (m_note[i] != 0) begin
        hp = CLK_HZ / (2 * FREQ[m_note[i]]);
        for (int k = 1; hp * k < lc; k++)
          if (p + hp * k <= stop_at) begin
            q_tog.push_back(p + hp * k);
            par = !par;
          end
      end
      t = p + lc;
      if (par && t <= stop_at) begin
        q_tog.push_back(t);
        par = 0;
      end
      i++;
      if (i == n) begin
        if (!loop) begin
          if (t <= stop_at) q_done.push_back(t);
          break;
        end
        i = 0;
      end
    end
    if (par) q_tog.push_back(stop_at + 1);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    n_chk += 4;
    if (speaker !== 1'b0) begin n_fail++; $display("FAIL reset_speaker: got %b, expected 0", speaker); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
    if (note_idx !== '0) begin n_fail++; $display("FAIL reset_note_idx: got %0d, expected 0", note_idx); end
    tick();
    rst = 0;
    mon_en = 1;
  endtask

  task automatic test_single_note();
    wr(0, 10, 1);
    model(1, BIG, 0);
    launch(1);
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (c == 0 || c == 1 || c == 241 || c == 242) begin
        n_chk++;
        if (busy !== (c == 1 || c == 241)) begin
          n_fail++;
          $display("FAIL single_busy: cycle %0d got %b, expected %b", c, busy, c == 1 || c == 241);
        end
      end
      tick();
    end
    n_chk++;
    if (q_tog.size() + q_done.size() + q_idx.size() != 0) begin
      n_fail++;
      $display("FAIL single_pending: %0d expected events never seen, expected 0", q_tog.size() + q_done.size() + q_idx.size());
    end
  endtask

  task automatic test_rest();
    int bad = 0;
    wr(0, 0, 0);
    model(1, BIG, 0);
    launch(1);
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      if (speaker !== 1'b0) bad++;
      if (c == 122) begin
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rest_busy: cycle 122 got %b, expected 0", busy); end
      end
      tick();
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL rest_speaker: %0d cycles high, expected 0", bad); end
    n_chk++;
    if (q_tog.size() + q_done.size() + q_idx.size() != 0) begin
      n_fail++;
      $display("FAIL rest_pending: %0d expected events never seen, expected 0", q_tog.size() + q_done.size() + q_idx.size());
    end
  endtask

  task automatic test_three_notes();
    wr(0, 1, 0);
    wr(1, 10, 0);
    wr(2, 13, 0);
    model(3, BIG, 0);
    launch(3);
    for (int c = 0; c < 380; c++) begin
      @(negedge clk);
      if (c == 121 || c == 122 || c == 243) begin
        n_chk++;
        if (int'(note_idx) != (c == 121 ? 0 : c == 122 ? 1 : 2)) begin
          n_fail++;
          $display("FAIL three_idx: cycle %0d got %0d, expected %0d", c, note_idx, c == 121 ? 0 : c == 122 ? 1 : 2);
        end
      end
      tick();
    end
    n_chk++;
    if (q_tog.size() + q_done.size() + q_idx.size() != 0) begin
      n_fail++;
      $display("FAIL three_pending: %0d expected events never seen, expected 0", q_tog.size() + q_done.size() + q_idx.size());
    end
  endtask

  task automatic test_abort();
    int bad = 0;
    wr(0, 10, 1);
    model(1, 50, 0);
    launch(1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 50) begin
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b, expected 1", busy); end
      end
      if (c == 51) begin
        n_chk++;
        if (busy !== 1'b0 || speaker !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_after: busy %b speaker %b, expected 0 0", busy, speaker);
        end
      end
      tick();
      if (c + 1 == 50) stop = 1;
    end
    n_chk++;
    if (q_tog.size() + q_done.size() + q_idx.size() != 0) begin
      n_fail++;
      $display("FAIL abort_pending: %0d expected events never seen, expected 0", q_tog.size() + q_done.size() + q_idx.size());
    end
    tick();
    start = 1; stop = 1; song_len = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
      tick();
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL start_stop_busy: %0d busy cycles, expected 0", bad); end
  endtask

  task automatic test_ignored();
    int bad = 0;
    tick();
    start = 1; song_len = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
      tick();
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL zero_len_busy: %0d busy cycles, expected 0", bad); end
    wr(0, 10, 0);
    wr(1, 1, 0);
    model(2, BIG, 0);
    launch(2);
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (c == 61) begin
        n_chk++;
        if (busy !== 1'b1 || note_idx !== '0) begin
          n_fail++;
          $display("FAIL restart_ignored: busy %b idx %0d, expected 1 0", busy, note_idx);
        end
      end
      tick();
      if (c + 1 == 60) begin start = 1; song_len = 1; end
    end
    n_chk++;
    if (q_tog.size() + q_done.size() + q_idx.size() != 0) begin
      n_fail++;
      $display("FAIL ignored_pending: %0d expected events never seen, expected 0", q_tog.size() + q_done.size() + q_idx.size());
    end
  endtask

  task automatic test_rst_mid_note();
    wr(0, 10, 1);
    model(1, 40, 0);
    launch(1);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 41) begin
        n_chk++;
        if (speaker !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== '0) begin
          n_fail++;
          $display("FAIL rst_mid: spk %b busy %b done %b idx %0d, expected all 0", speaker, busy, done, note_idx);
        end
      end
      tick();
      rst = (c + 1 == 40);
    end
    n_chk++;
    if (q_tog.size() + q_done.size() + q_idx.size() != 0) begin
      n_fail++;
      $display("FAIL rst_pending: %0d expected events never seen, expected 0", q_tog.size() + q_done.size() + q_idx.size());
    end
  endtask

  task automatic test_loop();
    wr(0, 10, 0);
    wr(1, 1, 0);
    model(2, 550, 1);
    launch(2);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 549 || c == 551) begin
        n_chk++;
        if (busy !== (c == 549)) begin n_fail++; $display("FAIL loop_busy: cycle %0d got %b, expected %b", c, busy, c == 549); end
      end
      tick();
      if (c + 1 == 550) stop = 1;
    end
    n_chk++;
    if (q_tog.size() + q_done.size() + q_idx.size() != 0) begin
      n_fail++;
      $display("FAIL loop_pending: %0d expected events never seen, expected 0", q_tog.size() + q_done.size() + q_idx.size());
    end
  endtask

  initial begin
    test_reset();
`ifdef MELODY_LOOP_EN
    test_loop();
`else
    test_single_note();
    test_rest();
    test_three_notes();
    test_abort();
    test_ignored();
    test_rst_mid_note();
`endif
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
